kbd_cmd_ctrl: RTL and testbench

- Parametrised successor to the lab-3 keyboard controller for the flash audio player.
- Synchronises the PS/2 ready strobe and decodes ASCII command letters into these controls:
  - play/pause
  - direction
  - restart request, with a done handshake
  - saturating playback-rate divider
- Sits between the PS/2 keyboard core and the flash-read / audio-sample FSMs.

---
 rtl/kbd_cmd_ctrl.sv | 136 +++++++++++++
 tb/tb_kbd_cmd_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_cmd_ctrl.sv
// Keyboard command controller: synchronises the PS/2 ready strobe and decodes ASCII letters
// into play/direction/restart/speed controls. Optional macro KBD_LOWER_CASE_EN accepts lowercase.
module kbd_cmd_ctrl #(
    parameter int unsigned LETTER_W      = 8,
    parameter int unsigned SPEED_W       = 16,
    parameter int unsigned SPEED_DEFAULT = 1136,
    parameter int unsigned SPEED_STEP    = 64,
    parameter int unsigned SPEED_MIN     = 256,
    parameter int unsigned SPEED_MAX     = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                kbd_ready,
    input  logic [LETTER_W-1:0] letter,
    input  logic                restart_done,
    output logic                start,
    output logic                direction,
    output logic                restart,
    output logic [SPEED_W-1:0]  speed_div,
    output logic                cmd_valid,
    output logic                cmd_err
);

    if (64'(SPEED_MAX) >= (64'd1 << SPEED_W) || SPEED_MIN > SPEED_MAX) begin : g_param_err
        $error("kbd_cmd_ctrl: speed bounds do not fit SPEED_W");
    end

    typedef enum logic {IDLE, WAIT_DONE} state_t;

    localparam logic [7:0] K_E = 8'h45;
    localparam logic [7:0] K_D = 8'h44;
    localparam logic [7:0] K_F = 8'h46;
    localparam logic [7:0] K_B = 8'h42;
    localparam logic [7:0] K_R = 8'h52;
    localparam logic [7:0] K_U = 8'h55;
    localparam logic [7:0] K_L = 8'h4C;
    localparam logic [7:0] K_N = 8'h4E;

    localparam logic [SPEED_W:0]   STEP_X = (SPEED_W+1)'(SPEED_STEP);
    localparam logic [SPEED_W:0]   MIN_X  = (SPEED_W+1)'(SPEED_MIN);
    localparam logic [SPEED_W:0]   MAX_X  = (SPEED_W+1)'(SPEED_MAX);
    localparam logic [SPEED_W-1:0] MIN_S  = SPEED_W'(SPEED_MIN);
    localparam logic [SPEED_W-1:0] MAX_S  = SPEED_W'(SPEED_MAX);
    localparam logic [SPEED_W-1:0] DEF_S  = SPEED_W'(SPEED_DEFAULT);

    state_t               state_q, state_d;
    logic                 s1_q, s2_q, s3_q;
    logic                 start_q, start_d;
    logic                 dir_q, dir_d;
    logic [SPEED_W-1:0]   speed_q, speed_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 ev;
    logic                 hi_zero;
    logic [7:0]           code;
    logic [SPEED_W:0]     spd_up, spd_dn;

    assign ev      = s2_q & ~s3_q;
    assign hi_zero = ((letter >> 8) == '0);
    assign spd_up  = {1'b0, speed_q} + STEP_X;
    assign spd_dn  = {1'b0, speed_q} - STEP_X;

    always_comb begin
        code = letter[7:0];
`ifdef KBD_LOWER_CASE_EN
        // Clearing bit 5 folds 'a'..'z' onto 'A'..'Z'.
        if (code >= 8'h61 && code <= 8'h7A) begin
            code = code & 8'hDF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            start_q <= 1'b0;
            dir_q   <= 1'b1;
            speed_q <= DEF_S;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= kbd_ready;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            start_q <= start_d;
            dir_q   <= dir_d;
            speed_q <= speed_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        dir_d   = dir_q;
        speed_d = speed_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (ev) begin
            valid_d = hi_zero;
            if (hi_zero) begin
                case (code)
                    K_E: start_d = 1'b1;
                    K_D: start_d = 1'b0;
                    K_F: dir_d   = 1'b1;
                    K_B: dir_d   = 1'b0;
                    K_R: begin
                        if (state_q == IDLE) state_d = WAIT_DONE;
                        else                 valid_d = 1'b0;
                    end
                    K_U: speed_d = (spd_dn[SPEED_W] || spd_dn < MIN_X) ? MIN_S : spd_dn[SPEED_W-1:0];
                    K_L: speed_d = (spd_up > MAX_X) ? MAX_S : spd_up[SPEED_W-1:0];
                    K_N: speed_d = DEF_S;
                    default: valid_d = 1'b0;
                endcase
            end
            err_d = ~valid_d;
        end
        if (state_q == WAIT_DONE && restart_done) begin
            state_d = IDLE;
        end
    end

    assign start     = start_q;
    assign direction = dir_q;
    assign restart   = (state_q == WAIT_DONE);
    assign speed_div = speed_q;
    assign cmd_valid = valid_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_kbd_cmd_ctrl.sv
// Directed self-checking bench for kbd_cmd_ctrl (default parameters).
module tb_kbd_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kbd_ready;
    logic [7:0]  letter;
    logic        restart_done;
    logic        start;
    logic        direction;
    logic        restart;
    logic [15:0] speed_div;
    logic        cmd_valid;
    logic        cmd_err;

    int tests = 0;
    int failed = 0;
    int nvalid = 0;
    int nerr = 0;
    int nboth = 0;

    kbd_cmd_ctrl #(
        .LETTER_W(8), .SPEED_W(16), .SPEED_DEFAULT(1136),
        .SPEED_STEP(64), .SPEED_MIN(256), .SPEED_MAX(4096)
    ) dut (
        .clk(clk), .rst_n(rst_n), .kbd_ready(kbd_ready), .letter(letter),
        .restart_done(restart_done), .start(start), .direction(direction),
        .restart(restart), .speed_div(speed_div), .cmd_valid(cmd_valid), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) nvalid++;
        if (cmd_err) nerr++;
        if (cmd_valid && cmd_err) nboth++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] l, input int hold);
        @(negedge clk);
        letter = l;
        kbd_ready = 1'b1;
        repeat (hold) @(negedge clk);
        kbd_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int v0, e0, exp_spd;
        rst_n = 1'b0;
        kbd_ready = 1'b0;
        letter = 8'h00;
        restart_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start), 0);
        chk("rst_dir", 32'(direction), 1);
        chk("rst_restart", 32'(restart), 0);
        chk("rst_speed", 32'(speed_div), 1136);
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_err", 32'(cmd_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 'E' with edge-accurate latency
        letter = 8'h45;
        kbd_ready = 1'b1;
        @(negedge clk);
        chk("E_edge1_start", 32'(start), 0);
        @(negedge clk);
        chk("E_edge2_start", 32'(start), 0);
        chk("E_edge2_valid", 32'(cmd_valid), 0);
        @(negedge clk);
        chk("E_edge3_start", 32'(start), 1);
        chk("E_edge3_valid", 32'(cmd_valid), 1);
        @(negedge clk);
        chk("E_edge4_valid", 32'(cmd_valid), 0);
        kbd_ready = 1'b0;
        repeat (4) @(negedge clk);

        press(8'h44, 4);
        chk("D_start", 32'(start), 0);

        press(8'h42, 4);
        chk("B_dir", 32'(direction), 0);
        v0 = nvalid;
        press(8'h46, 20);
        chk("F_dir", 32'(direction), 1);
        chk("hold_one_valid", 32'(nvalid - v0), 1);

        // Restart with delayed acknowledge
        v0 = nvalid;
        press(8'h52, 4);
        chk("R_restart", 32'(restart), 1);
        chk("R_valid", 32'(nvalid - v0), 1);
        v0 = nvalid; e0 = nerr;
        press(8'h52, 4);
        chk("R2_err", 32'(nerr - e0), 1);
        chk("R2_no_valid", 32'(nvalid - v0), 0);
        chk("R2_restart", 32'(restart), 1);
        press(8'h45, 4);
        chk("wait_E_start", 32'(start), 1);
        repeat (10) @(negedge clk);
        chk("R_held", 32'(restart), 1);
        restart_done = 1'b1;
        chk("R_before_done", 32'(restart), 1);
        @(negedge clk);
        chk("R_after_done", 32'(restart), 0);
        restart_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("R_idle", 32'(restart), 0);

        // Restart with done already high: one-cycle request
        restart_done = 1'b1;
        @(negedge clk);
        letter = 8'h52;
        kbd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("Rt_edge2", 32'(restart), 0);
        @(negedge clk);
        chk("Rt_edge3", 32'(restart), 1);
        chk("Rt_valid", 32'(cmd_valid), 1);
        @(negedge clk);
        chk("Rt_edge4", 32'(restart), 0);
        kbd_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("Rt_idle", 32'(restart), 0);
        restart_done = 1'b0;

        // 'U' x20: 1136 -> ... 304 -> 256 clamp
        exp_spd = 1136;
        for (int i = 0; i < 20; i++) begin
            press(8'h55, 3);
            exp_spd = (exp_spd - 64 < 256) ? 256 : exp_spd - 64;
            chk($sformatf("U_%0d", i), 32'(speed_div), 32'(exp_spd));
        end
        chk("U_clamp", 32'(speed_div), 256);
        // 'L' x62: 256 -> 4096 exactly at 60, then clamps
        for (int i = 0; i < 62; i++) begin
            press(8'h4C, 3);
            exp_spd = (exp_spd + 64 > 4096) ? 4096 : exp_spd + 64;
            chk($sformatf("L_%0d", i), 32'(speed_div), 32'(exp_spd));
        end
        chk("L_clamp", 32'(speed_div), 4096);
        press(8'h4E, 3);
        chk("N_speed", 32'(speed_div), 1136);

        // Unrecognised and lowercase letters
        press(8'h44, 3);
        chk("D2_start", 32'(start), 0);
        e0 = nerr; v0 = nvalid;
        press(8'h5A, 3);
        chk("Z_err", 32'(nerr - e0), 1);
        chk("Z_no_valid", 32'(nvalid - v0), 0);
        chk("Z_start", 32'(start), 0);
        chk("Z_dir", 32'(direction), 1);
        chk("Z_speed", 32'(speed_div), 1136);
        e0 = nerr; v0 = nvalid;
        press(8'h65, 3);
`ifdef KBD_LOWER_CASE_EN
        chk("e_start", 32'(start), 1);
        chk("e_valid", 32'(nvalid - v0), 1);
        chk("e_err", 32'(nerr - e0), 0);
`else
        chk("e_start", 32'(start), 0);
        chk("e_valid", 32'(nvalid - v0), 0);
        chk("e_err", 32'(nerr - e0), 1);
`endif

        // Async reset in the middle of WAIT_DONE
        press(8'h45, 3);
        press(8'h42, 3);
        press(8'h4C, 3);
        chk("pre_speed", 32'(speed_div), 1200);
        press(8'h52, 3);
        chk("pre_restart", 32'(restart), 1);
        chk("pre_start", 32'(start), 1);
        chk("pre_dir", 32'(direction), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(start), 0);
        chk("arst_dir", 32'(direction), 1);
        chk("arst_restart", 32'(restart), 0);
        chk("arst_speed", 32'(speed_div), 1136);
        chk("arst_valid", 32'(cmd_valid), 0);
        chk("arst_err", 32'(cmd_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_restart", 32'(restart), 0);

        chk("valid_err_exclusive", 32'(nboth), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
